// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts one instruction, reads up to two source registers
// from a one-cycle-latency register file and issues opcode/operands downstream.
package constants;
  localparam int WORD_SIZE = 19;
endpackage

package opcodes;
  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;
  localparam logic [4:0] OP_INC = 5'd5;
  localparam logic [4:0] OP_DEC = 5'd6;
endpackage

module operand_fetch
  import opcodes::*;
#(
  parameter int WORD_SIZE = constants::WORD_SIZE,
  parameter int REG_AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [WORD_SIZE-1:0] instr,
  output logic                 rf_rd_en,
  output logic [REG_AW-1:0]    rf_rd_addr,
  input  logic [WORD_SIZE-1:0] rf_rd_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [4:0]           ex_opcode,
  output logic [REG_AW-1:0]    ex_rd,
  output logic [WORD_SIZE-1:0] operand_1,
  output logic [WORD_SIZE-1:0] operand_2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_CAP,
    S_ISSUE
  } state_t;

  state_t            r_state;
  logic [4:0]        r_opcode;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs2;
  logic              r_binary;

  logic [4:0]        w_opcode;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic              w_is_binary;
  logic              w_is_unary;
  logic              w_accept;
  logic              w_unused_rsvd;

  assign w_opcode      = instr[WORD_SIZE-1 -: 5];
  assign w_rd          = instr[WORD_SIZE-6 -: REG_AW];
  assign w_rs1         = instr[WORD_SIZE-6-REG_AW -: REG_AW];
  assign w_rs2         = instr[WORD_SIZE-6-2*REG_AW -: REG_AW];
  assign w_unused_rsvd = ^instr[WORD_SIZE-6-3*REG_AW:0];

  assign w_is_binary = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                       (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
  assign w_is_unary  = (w_opcode == OP_INC) || (w_opcode == OP_DEC);

  // instr_ready is itself registered, so the first IDLE cycle after reset refuses input.
  assign w_accept = (r_state == S_IDLE) && instr_ready && instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_opcode    <= '0;
      r_rd        <= '0;
      r_rs2       <= '0;
      r_binary    <= 1'b0;
      instr_ready <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_rd_addr  <= '0;
      ex_valid    <= 1'b0;
      ex_opcode   <= '0;
      ex_rd       <= '0;
      operand_1   <= '0;
      operand_2   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            instr_ready <= 1'b0;
            r_opcode    <= w_opcode;
            r_rd        <= w_rd;
            r_rs2       <= w_rs2;
            r_binary    <= w_is_binary;
            if (w_is_binary || w_is_unary) begin
              r_state    <= S_RD1;
              rf_rd_en   <= 1'b1;
              rf_rd_addr <= w_rs1;
            end else begin
              r_state   <= S_ISSUE;
              ex_valid  <= 1'b1;
              ex_opcode <= w_opcode;
              ex_rd     <= w_rd;
              operand_1 <= '0;
              operand_2 <= '0;
            end
          end else begin
            instr_ready <= 1'b1;
          end
        end

        S_RD1: begin
          if (r_binary) begin
            r_state    <= S_RD2;
            rf_rd_addr <= r_rs2;
          end else begin
            r_state    <= S_CAP;
            rf_rd_en   <= 1'b0;
            rf_rd_addr <= '0;
          end
        end

        // rs1 data returns here while the rs2 read is on the bus.
        S_RD2: begin
          operand_1  <= rf_rd_data;
          r_state    <= S_CAP;
          rf_rd_en   <= 1'b0;
          rf_rd_addr <= '0;
        end

        S_CAP: begin
          if (r_binary) begin
            operand_2 <= rf_rd_data;
          end else begin
            operand_1 <= rf_rd_data;
            operand_2 <= '0;
          end
          ex_valid  <= 1'b1;
          ex_opcode <= r_opcode;
          ex_rd     <= r_rd;
          r_state   <= S_ISSUE;
        end

        S_ISSUE: begin
          if (ex_ready) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_rd       <= '0;
            operand_1   <= '0;
            operand_2   <= '0;
            instr_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          instr_ready <= 1'b0;
          rf_rd_en    <= 1'b0;
          rf_rd_addr  <= '0;
          ex_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomised bench for operand_fetch: a register-file model plus an
// instruction-level reference (class, latency, expected operands).
module tb_operand_fetch;
  import opcodes::*;

  localparam int WS = 19;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [WS-1:0] instr = '0;
  logic          rf_rd_en;
  logic [AW-1:0] rf_rd_addr;
  logic [WS-1:0] rf_rd_data;
  logic          ex_valid;
  logic          ex_ready = 1'b0;
  logic [4:0]    ex_opcode;
  logic [AW-1:0] ex_rd;
  logic [WS-1:0] operand_1;
  logic [WS-1:0] operand_2;

  logic [WS-1:0] rf [16];

  int n_checks = 0;
  int n_errors = 0;

  operand_fetch #(.WORD_SIZE(WS), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .operand_1(operand_1), .operand_2(operand_2)
  );

  always #5 clk = ~clk;

  // Register file returns data one cycle after the strobe; garbage otherwise.
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];
    else          rf_rd_data <= WS'($urandom);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 2 = binary, 1 = unary, 0 = other
  function automatic int op_class(input logic [4:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_MUL || op == OP_DIV) return 2;
    if (op == OP_INC || op == OP_DEC) return 1;
    return 0;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_ex_valid"}, ex_valid, 0);
    check({tag, "_rd_en"}, rf_rd_en, 0);
    check({tag, "_rd_addr"}, rf_rd_addr, 0);
    check({tag, "_opcode"}, ex_opcode, 0);
    check({tag, "_rd"}, ex_rd, 0);
    check({tag, "_op1"}, operand_1, 0);
    check({tag, "_op2"}, operand_2, 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", instr_ready, 1);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [3:0] rd,
                           input logic [3:0] rs1, input logic [3:0] rs2, input int stall);
    int cls, lat;
    logic [WS-1:0] e1, e2;
    logic exp_en, exp_v;
    logic [3:0] exp_addr;
    cls = op_class(op);
    lat = (cls == 2) ? 4 : (cls == 1) ? 3 : 1;
    e1  = (cls > 0) ? rf[rs1] : '0;
    e2  = (cls == 2) ? rf[rs2] : '0;
    wait_ready();
    instr = {op, rd, rs1, rs2, 2'($urandom)};
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = WS'($urandom);
    for (int k = 1; k <= lat + stall; k++) begin
      @(negedge clk);
      check("ready_busy", instr_ready, 0);
      exp_en   = (cls == 2 && (k == 1 || k == 2)) || (cls == 1 && k == 1);
      exp_addr = !exp_en ? 4'd0 : (k == 1) ? rs1 : rs2;
      check("rd_en", rf_rd_en, exp_en);
      check("rd_addr", rf_rd_addr, exp_addr);
      exp_v = (k >= lat);
      check("ex_valid", ex_valid, exp_v);
      if (exp_v) begin
        check("ex_opcode", ex_opcode, op);
        check("ex_rd", ex_rd, rd);
        check("operand_1", operand_1, e1);
        check("operand_2", operand_2, e2);
        ex_ready = (k - lat >= stall);
      end else begin
        ex_ready = 1'($urandom);
      end
    end
    @(negedge clk);
    check("post_ready", instr_ready, 1);
    check_idle_zero("post");
    $display("instr op=%0d rd=%0d rs1=%0d rs2=%0d stall=%0d op1=%05h op2=%05h",
             op, rd, rs1, rs2, stall, e1, e2);
    ex_ready = 1'($urandom);
  endtask

  initial begin
    logic [4:0] op;
    logic [WS-1:0] cur1, cur2, nxt1, nxt2;
    logic [3:0] r1, r2;
    int acc, n_acc;

    for (int i = 0; i < 16; i++) rf[i] = WS'($urandom);

    // Reset must clear outputs asynchronously, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_ready", instr_ready, 0);
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("release_ready", instr_ready, 0);
    @(negedge clk);
    check("first_edge_ready", instr_ready, 1);

    // Directed cases
    rf[3] = 19'h00005; rf[7] = 19'h0000A;
    run_instr(OP_ADD, 4'd1, 4'd3, 4'd7, 0);
    rf[15] = 19'h7FFFF;
    run_instr(OP_INC, 4'd2, 4'd15, 4'd9, 0);
    run_instr(5'h1F, 4'd5, 4'd3, 4'd7, 0);
    run_instr(OP_SUB, 4'd6, 4'd3, 4'd15, 6);
    run_instr(OP_MUL, 4'd4, 4'd9, 4'd9, 0);

    // Reset during RD2 of MUL abandons the instruction.
    wait_ready();
    instr = {OP_MUL, 4'd8, 4'd3, 4'd7, 2'b00};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rd2_en", rf_rd_en, 1);
    check("rd2_addr", rf_rd_addr, 7);
    rst_n = 1'b0;
    #1;
    check("async_ready", instr_ready, 0);
    check_idle_zero("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_ex_after_reset", ex_valid, 0);
      check("ready_after_reset", instr_ready, 1);
    end
    $display("reset during MUL RD2 abandoned");
    run_instr(OP_ADD, 4'd3, 4'd7, 4'd3, 1);

    // DIV stream with instr_valid held high: accepts exactly 5 cycles apart.
    ex_ready = 1'b1;
    wait_ready();
    r1 = 4'($urandom); r2 = 4'($urandom);
    instr = {OP_DIV, 4'd10, r1, r2, 2'b11};
    cur1 = rf[r1]; cur2 = rf[r2];
    nxt1 = '0; nxt2 = '0;
    instr_valid = 1'b1;
    acc = 0; n_acc = 1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == acc + 1) begin
        r1 = 4'($urandom); r2 = 4'($urandom);
        instr = {OP_DIV, 4'd10, r1, r2, 2'b01};
        nxt1 = rf[r1]; nxt2 = rf[r2];
      end
      check("stream_ex_valid", ex_valid, (c == acc + 4));
      if (c == acc + 4) begin
        check("stream_op1", operand_1, cur1);
        check("stream_op2", operand_2, cur2);
        $display("stream DIV issue at cycle %0d op1=%05h op2=%05h", c, operand_1, operand_2);
      end
      check("stream_ready", instr_ready, (c == acc + 5));
      if (instr_ready === 1'b1) begin
        acc = c;
        n_acc++;
        cur1 = nxt1; cur2 = nxt2;
      end
    end
    instr_valid = 1'b0;
    check("stream_accepts", n_acc, 5);

    // Randomised instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) rf[$urandom_range(0, 15)] = WS'($urandom);
      op = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 6)) : 5'($urandom);
      run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter WORD_SIZE, default constants::WORD_SIZE (19), datapath and instruction width; opcode encodings from package opcodes.
REQ-002 Parameter REG_AW, default 4, register-file address width (16 registers).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 instr_valid  input  1  upstream instruction valid.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 instr  input  WORD_SIZE  {opcode[18:14], rd[13:10], rs1[9:6], rs2[5:2], rsvd[1:0]}; rsvd ignored.
REQ-008 rf_rd_en  output  1  register-file read strobe.
REQ-009 rf_rd_addr  output  REG_AW  register-file read address.
REQ-010 rf_rd_data  input  WORD_SIZE  read data, valid exactly one cycle after rf_rd_en.
REQ-011 ex_valid  output  1  operands valid toward arithmetic unit.
REQ-012 ex_ready  input  1  arithmetic stage accepts operands.
REQ-013 ex_opcode  output  5  opcode for arithmetic unit.
REQ-014 ex_rd  output  REG_AW  destination register, passed through.
REQ-015 operand_1  output  WORD_SIZE  first operand.
REQ-016 operand_2  output  WORD_SIZE  second operand.

Function
REQ-017 FSM states: IDLE, RD1, RD2, CAP, ISSUE; all outputs registered.
REQ-018 IDLE: instr_ready=1, all else 0; instr_valid=1 latches opcode, rd, rs1, rs2 and leaves IDLE next cycle.
REQ-019 instr_ready SHALL be 0 in every state except IDLE; no instruction accepted outside IDLE.
REQ-020 Class: binary = ADD, SUB, MUL, DIV; unary = INC, DEC; other = any remaining opcode (NOP class).
REQ-021 Binary/unary: IDLE -> RD1; RD1 drives rf_rd_en=1, rf_rd_addr=rs1.
REQ-022 Binary: RD1 -> RD2; RD2 drives rf_rd_en=1, rf_rd_addr=rs2 and captures rf_rd_data into operand_1; RD2 -> CAP.
REQ-023 Unary: RD1 -> CAP; CAP captures rf_rd_data into operand_1, operand_2=0.
REQ-024 Binary CAP captures rf_rd_data into operand_2; CAP -> ISSUE, rf_rd_en=0 in CAP.
REQ-025 Other class: IDLE -> ISSUE directly, no reads, operand_1=operand_2=0, ex_opcode=latched opcode.
REQ-026 Latency from accept cycle T: ex_valid high at T+4 (binary), T+3 (unary), T+1 (other).
REQ-027 ISSUE: ex_valid=1; ex_opcode, ex_rd, operand_1, operand_2 SHALL stay stable while ex_valid=1 and ex_ready=0.
REQ-028 ISSUE with ex_ready=1: handshake completes, ex_valid=0 next cycle, state -> IDLE.
REQ-029 ex_ready high outside ISSUE SHALL have no effect.
REQ-030 rs1==rs2 SHALL still perform two reads; both operands equal.
REQ-031 rf_rd_addr SHALL be 0 whenever rf_rd_en=0.
REQ-032 Maximum throughput: one instruction per 5 cycles (binary), back-to-back not supported.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, ex_valid=0, rf_rd_en=0, rf_rd_addr=0, ex_opcode=0, ex_rd=0, operand_1=0, operand_2=0, instr_ready=0.
REQ-034 instr_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-035 Reset in any state SHALL abandon the in-flight instruction; no ex_valid pulse follows.

Verification
REQ-036 ADD, rs1=3 (RF=0x00005), rs2=7 (RF=0x0000A), ex_ready=1 -> reads addr 3 at T+1, 7 at T+2; ex_valid at T+4 with operand_1=0x00005, operand_2=0x0000A, single cycle.
REQ-037 INC, rs1=15 (RF=0x7FFFF) -> one read only, ex_valid at T+3, operand_1=0x7FFFF, operand_2=0.
REQ-038 Opcode outside defined set -> no rf_rd_en, ex_valid at T+1, operands 0.
REQ-039 SUB issued with ex_ready=0 for 6 cycles -> ex_valid and all ex outputs constant 6 cycles, instr_ready=0; drops one cycle after ex_ready=1.
REQ-040 rst_n asserted during RD2 of MUL -> outputs zero asynchronously, no ex_valid after release, next instruction processed normally.
REQ-041 instr_valid held high continuously with DIV stream -> each instruction accepted only in IDLE, exactly 5 cycles apart.
